dmem_mmio: RTL and testbench

Data-memory stage for the 5-stage MIPS pipeline: consumes the memory-stage outputs (`MemWriteM`, `ALUOutM`, `WriteDataM`) and returns `DmmRD`, which the pipeline captures into its memory/writeback register on the next edge. It contains a word-addressed data RAM and a small memory-mapped I/O window: a console TX FIFO drained by an external consumer, a status register and a free-running cycle counter. Reads are combinational and side-effect free; all state changes happen on the rising clock edge.

---
 rtl/dmem_mmio.sv | 175 +++++++++++++++++
 tb/tb_dmem_mmio.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - MIPS memory-stage data RAM with console TX FIFO, status and cycle-counter MMIO
//
// Purpose:
//   Word-addressed data RAM plus a small memory-mapped I/O window.
//   Reads are combinational and side-effect free. All state changes
//   happen on the rising clock edge.
//
//   Address map (full 32-bit decode):
//     0x0000_0000 .. DEPTH_WORDS*4-1 : RAM
//     0xFFFF_0000                    : TXDATA (store pushes byte, reads 0)
//     0xFFFF_0004                    : STATUS {count[7:4], overflow, empty, full}
//     0xFFFF_0008                    : CYCLE  (free-running, store loads)
//     anything else                  : reads 0, stores ignored
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   MemWriteM    in   store strobe
//   ALUOutM      in   [31:0] byte address
//   WriteDataM   in   [31:0] store data
//   DmmRD        out  [31:0] combinational read data for ALUOutM
//   tx_data      out  [7:0]  FIFO head byte (0 while empty)
//   tx_valid     out  FIFO non-empty
//   tx_ready     in   consumer pops head when tx_valid && tx_ready
//   misalign_err out  sticky, set by any store with ALUOutM[1:0] != 0

module dmem_mmio #(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] DmmRD,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);

  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);

  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_0008;

  localparam logic [3:0]          FIFO_FULL_COUNT = 4'(FIFO_DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE         = PTR_BITS'(1);

  // Storage and registered state
  logic [31:0]         ram [DEPTH_WORDS];
  logic [7:0]          fifoMem [FIFO_DEPTH];
  logic [PTR_BITS-1:0] rdPtr;
  logic [PTR_BITS-1:0] wrPtr;
  logic [3:0]          fifoCount;
  logic                overflow;
  logic                misalignReg;
  logic [31:0]         cycleCount;

  // Address decode
  logic                 inRam;
  logic                 isTxData;
  logic                 isStatus;
  logic                 isCycle;
  logic                 aligned;
  logic [ADDR_BITS-1:0] ramIdx;

  // RAM covers exactly the low DEPTH_WORDS*4 bytes; higher addresses must not alias.
  assign inRam    = (ALUOutM[31:ADDR_BITS+2] == '0);
  assign ramIdx   = ALUOutM[ADDR_BITS+1:2];
  // MMIO needs an exact match, so misaligned MMIO addresses decode to nothing.
  assign isTxData = (ALUOutM == TXDATA_ADDR);
  assign isStatus = (ALUOutM == STATUS_ADDR);
  assign isCycle  = (ALUOutM == CYCLE_ADDR);
  assign aligned  = (ALUOutM[1:0] == 2'b00);

  // FIFO flags and handshakes
  logic fifoFull;
  logic fifoEmpty;
  logic storeOk;
  logic pushReq;
  logic pushDo;
  logic popDo;

  assign fifoFull  = (fifoCount == FIFO_FULL_COUNT);
  assign fifoEmpty = (fifoCount == 4'd0);
  assign storeOk   = MemWriteM && aligned;
  assign pushReq   = storeOk && isTxData;
  // Full is judged before the edge: a same-cycle pop does not make room.
  assign pushDo    = pushReq && !fifoFull;
  assign popDo     = tx_valid && tx_ready;

  assign tx_valid     = !fifoEmpty;
  // Head comes straight from FIFO registers; forced to 0 while empty so reset shows 0.
  assign tx_data      = fifoEmpty ? 8'h00 : fifoMem[rdPtr];
  assign misalign_err = misalignReg;

  // Combinational read mux
  logic [31:0] statusWord;
  assign statusWord = {24'h0, fifoCount, 1'b0, overflow, fifoEmpty, fifoFull};

  always_comb begin
    DmmRD = 32'h0;
    if (inRam) begin
      DmmRD = ram[ramIdx];
    end else if (isStatus) begin
      DmmRD = statusWord;
    end else if (isCycle) begin
      DmmRD = cycleCount;
    end
  end

  // RAM: not reset; reset still blocks a concurrent store.
  always_ff @(posedge clk) begin
    if (!reset && storeOk && inRam) begin
      ram[ramIdx] <= WriteDataM;
    end
  end

  // FIFO storage array (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (!reset && pushDo) begin
      fifoMem[wrPtr] <= WriteDataM[7:0];
    end
  end

  // FIFO pointers, count and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCount <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      if (pushDo) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (popDo) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (pushDo && !popDo) begin
        fifoCount <= fifoCount + 4'd1;
      end else if (popDo && !pushDo) begin
        fifoCount <= fifoCount - 4'd1;
      end
      if (pushReq && fifoFull) begin
        overflow <= 1'b1;
      end
    end
  end

  // Cycle counter: a CYCLE store wins over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycleCount <= 32'h0;
    end else if (storeOk && isCycle) begin
      cycleCount <= WriteDataM;
    end else begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  // Sticky misaligned-store flag
  always_ff @(posedge clk) begin
    if (reset) begin
      misalignReg <= 1'b0;
    end else if (MemWriteM && !aligned) begin
      misalignReg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed self-checking bench for dmem_mmio

module tb_dmem_mmio;

  localparam logic [31:0] TXA = 32'hFFFF_0000;
  localparam logic [31:0] STA = 32'hFFFF_0004;
  localparam logic [31:0] CYA = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] DmmRD;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  dmem_mmio #(.DEPTH_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .ALUOutM      (ALUOutM),
    .WriteDataM   (WriteDataM),
    .DmmRD        (DmmRD),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    MemWriteM  = we;
    ALUOutM    = addr;
    WriteDataM = data;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    tx_ready   = 1'b0;
    MemWriteM  = 1'b0;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    setBus(1'b0, STA, 32'h0);
    check("rst_status", DmmRD, 32'h0000_0002);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    setBus(1'b0, CYA, 32'h0);
    check("rst_cycle0", DmmRD, 32'h0);
    tick();
    check("rst_cycle1", DmmRD, 32'h1);

    // RAM store and read-during-write
    setBus(1'b1, 32'h0000_0010, 32'h1111_1111);
    tick();
    setBus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("ram_rdw_old", DmmRD, 32'h1111_1111);
    tick();
    setBus(1'b0, 32'h0000_0010, 32'h0);
    check("ram_new", DmmRD, 32'hDEAD_BEEF);

    // Out-of-range store must not alias word 0
    setBus(1'b1, 32'h0000_0000, 32'h0A0A_0A0A);
    tick();
    setBus(1'b1, 32'h0000_1000, 32'hCAFE_F00D);
    tick();
    setBus(1'b0, 32'h0000_1000, 32'h0);
    check("oor_read0", DmmRD, 32'h0);
    setBus(1'b0, 32'h0000_0000, 32'h0);
    check("oor_no_alias", DmmRD, 32'h0A0A_0A0A);
    setBus(1'b0, 32'h0000_03FC, 32'h0);
    setBus(1'b0, 32'hFFFF_000C, 32'h0);
    check("unmapped_read", DmmRD, 32'h0);
    setBus(1'b0, TXA, 32'h0);
    check("txdata_read", DmmRD, 32'h0);

    // FIFO fill and overflow
    for (int i = 0; i < 9; i++) begin
      setBus(1'b1, TXA, 32'h41 + i);
      tick();
      if (i == 7) begin
        setBus(1'b0, STA, 32'h0);
        check("fifo_full_status", DmmRD, 32'h0000_0081);
        check("fifo_head_full", {24'h0, tx_data}, 32'h41);
      end
    end
    setBus(1'b0, STA, 32'h0);
    check("fifo_ovf_status", DmmRD, 32'h0000_0085);

    // STATUS writes are ignored
    setBus(1'b1, STA, 32'hFFFF_FFFF);
    tick();
    setBus(1'b0, STA, 32'h0);
    check("status_wr_ignored", DmmRD, 32'h0000_0085);

    // Drain in order
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_byte", {24'h0, tx_data}, 32'h41 + i);
      check("drain_valid", {31'h0, tx_valid}, 32'h1);
      tick();
    end
    tx_ready = 1'b0;
    #1;
    check("drain_end_status", DmmRD, 32'h0000_0006);
    check("drain_end_valid", {31'h0, tx_valid}, 32'h0);

    // Push and pop together at count 3
    for (int i = 0; i < 3; i++) begin
      setBus(1'b1, TXA, 32'h50 + i);
      tick();
    end
    tx_ready = 1'b1;
    setBus(1'b1, TXA, 32'h53);
    check("pp3_head_before", {24'h0, tx_data}, 32'h50);
    tick();
    tx_ready = 1'b0;
    setBus(1'b0, STA, 32'h0);
    check("pp3_status", DmmRD, 32'h0000_0034);
    check("pp3_head_after", {24'h0, tx_data}, 32'h51);

    // Reset mid-burst discards FIFO and clears overflow
    reset = 1'b1;
    setBus(1'b1, TXA, 32'h99);
    tick();
    reset = 1'b0;
    setBus(1'b0, STA, 32'h0);
    check("midrst_status", DmmRD, 32'h0000_0002);
    check("midrst_tx_data", {24'h0, tx_data}, 32'h0);

    // Push and pop together at full: push dropped, overflow set
    for (int i = 0; i < 8; i++) begin
      setBus(1'b1, TXA, 32'h60 + i);
      tick();
    end
    setBus(1'b0, STA, 32'h0);
    check("full2_status", DmmRD, 32'h0000_0081);
    tx_ready = 1'b1;
    setBus(1'b1, TXA, 32'h68);
    tick();
    tx_ready = 1'b0;
    setBus(1'b0, STA, 32'h0);
    check("ppfull_status", DmmRD, 32'h0000_0074);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("ppfull_drain", {24'h0, tx_data}, 32'h61 + i);
      tick();
    end
    tx_ready = 1'b0;
    #1;
    check("ppfull_end_status", DmmRD, 32'h0000_0006);

    // Cycle counter load and wrap
    setBus(1'b1, CYA, 32'hFFFF_FFFE);
    tick();
    setBus(1'b0, CYA, 32'h0);
    check("cyc_load", DmmRD, 32'hFFFF_FFFE);
    tick();
    check("cyc_max", DmmRD, 32'hFFFF_FFFF);
    tick();
    check("cyc_wrap", DmmRD, 32'h0);

    // Misaligned stores
    setBus(1'b1, 32'h0000_0012, 32'h1234_5678);
    tick();
    setBus(1'b0, 32'h0000_0010, 32'h0);
    check("mis_ram_unchanged", DmmRD, 32'hDEAD_BEEF);
    check("mis_flag_set", {31'h0, misalign_err}, 32'h1);
    setBus(1'b0, 32'h0000_0012, 32'h0);
    check("mis_read_aligned_down", DmmRD, 32'hDEAD_BEEF);
    setBus(1'b1, 32'hFFFF_0001, 32'h77);
    tick();
    setBus(1'b0, STA, 32'h0);
    check("mis_no_push_valid", {31'h0, tx_valid}, 32'h0);
    check("mis_no_push_status", DmmRD, 32'h0000_0006);
    setBus(1'b0, 32'hFFFF_0005, 32'h0);
    check("mis_mmio_read0", DmmRD, 32'h0);
    tick();
    tick();
    check("mis_flag_sticky", {31'h0, misalign_err}, 32'h1);

    // Reset clears sticky flags
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setBus(1'b0, STA, 32'h0);
    check("final_rst_misalign", {31'h0, misalign_err}, 32'h0);
    check("final_rst_status", DmmRD, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
